pipe_control_unit: RTL and testbench
====================================

PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 Parameter M_EXT, default 1: 1 decodes R-type with inst[25]=1 as multiply/divide; 0 flags it illegal.
REQ-002 Parameter HALT_RESUME, default 1: 1 exits HALT on resume; 0 HALT is held until reset.
REQ-003 Parameter FENCE_RST_CYCLES, default 1, legal range 1..15: pc_rst pulse length in cycles.
REQ-004 Parameter ILLEGAL_HALT, default 0: 1 sends an illegal opcode to HALT; 0 converts it to a bubble only.
REQ-005 Ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset.
REQ-006 inst in 32, instruction from the fetch stage; in_valid in 1, inst is valid.
REQ-007 stall in 1, hold the decode register; flush in 1, kill the instruction being captured; resume in 1, HALT release request.
REQ-008 out_valid out 1; AluOp out 4; MemRead, MemWrite, RegWrite, ALUSrc, MemToReg out 1 each; RegData out 2; Branch out 2; all registered.
REQ-009 pc_rst out 1, pc_halt out 1, illegal out 1 (one-cycle pulse); all registered.

Function
REQ-010 Decode SHALL use inst[6:2]; per-opcode encodings (AluOp/RegData/Branch) SHALL be:
- Branch 0010/01/01; Load 0011/10/00; Store 0100/01/00; JALR 0101/00/11; JAL 0110/00/10.
- Arith_I 0001/10/00; Arith_R 0000/10/00 (MUL group 1001); AUIPC 0111/01/00; LUI 1000/10/00.
REQ-011 Each decoded opcode SHALL drive the matching MemRead/MemWrite/RegWrite/ALUSrc/MemToReg values; Load SHALL be the only opcode with MemRead=1 and MemToReg=1.
REQ-012 Latency SHALL be one cycle: an instruction accepted at edge N appears on the outputs after edge N.
REQ-013 Accept = in_valid & !stall & !flush & state==RUN.
REQ-014 On acceptance, the outputs SHALL load the decoded bundle and out_valid<=1.
REQ-015 stall=1 without flush SHALL hold all control outputs and out_valid unchanged.
REQ-016 flush=1 SHALL load a bubble (all controls 0, out_valid 0) regardless of stall; flush beats stall.
REQ-017 No acceptance and no stall SHALL load a bubble.
REQ-018 FSM states: RUN, HALT, RSTP.
REQ-019 RUN transitions on an accepted instruction:
- ECALL (SYSTEM, inst[21]=0) -> HALT.
- FENCE -> RSTP, counter loaded with FENCE_RST_CYCLES-1.
- EBREAK (inst[21]=1) -> stays in RUN and emits a valid all-zero NOP.
REQ-020 SYSTEM and FENCE SHALL emit all-zero controls; no RegWrite or MemWrite.
REQ-021 HALT: pc_halt=1 and out_valid=0 each cycle; resume=1 with HALT_RESUME=1 -> RUN; the instruction presented in the resume cycle is not accepted.
REQ-022 RSTP: pc_rst=1 and out_valid=0 each cycle; the counter decrements and the FSM returns to RUN after the cycle with counter==0, so pc_rst is high exactly FENCE_RST_CYCLES cycles.
REQ-023 in_valid SHALL be ignored in HALT and RSTP.
REQ-024 An unknown opcode, or MUL with M_EXT=0, SHALL be accepted as a bubble with illegal=1 for one cycle; with ILLEGAL_HALT=1 the FSM goes to HALT.
REQ-025 A flushed ECALL or FENCE SHALL cause no state change.
REQ-026 resume in RUN or RSTP SHALL be ignored.

Reset
REQ-027 rst=0 SHALL asynchronously force state RUN, counter 0, out_valid 0, all control outputs 0, pc_rst 0, pc_halt 0, illegal 0.
REQ-028 This applies in any state, including mid-RSTP; after release, the first acceptance SHALL be possible at the first rising edge.

Structure
REQ-029 Opcode, AluOp, RegData and Branch encodings SHALL live in the shared defines file; no literals in the module body.
REQ-030 One combinational sub-module, ctrl_decode (inst in, bundle + is_ecall/is_fence/is_illegal out), SHALL hold the decode; pipe_control_unit holds the register, FSM and counter.

Verification
REQ-031 inst 0x003100B3 (add), in_valid=1 -> next cycle out_valid=1, AluOp=0000, RegWrite=1, RegData=10, ALUSrc=0.
REQ-032 inst 0x023100B3 (mul): M_EXT=1 -> AluOp=1001; M_EXT=0 -> illegal pulse=1, out_valid=0.
REQ-033 inst 0x0000A083 (lw) captured, then stall=1 for 3 cycles -> outputs held (MemRead=1); stall=1 and flush=1 together -> bubble next cycle.
REQ-034 inst 0x00000073 (ecall) -> pc_halt=1 from the next cycle and held for 10 cycles; resume=1 -> pc_halt=0 next cycle; HALT_RESUME=0 -> pc_halt stays 1 until rst.
REQ-035 inst 0x0000000F (fence), FENCE_RST_CYCLES=3 -> pc_rst=1 for exactly 3 cycles; rst asserted in the 2nd cycle -> pc_rst=0 immediately, state RUN.

Source files
------------

// File: rtl/pipe_control_unit_pkg.sv
// pipe_control_unit_pkg: opcode, control-field and FSM encodings shared by the decode-stage control unit.
package pipe_control_unit_pkg;

    // RISC-V major opcodes, inst[6:2]
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    // instruction bits that split an opcode group
    localparam int MUL_BIT    = 25;
    localparam int EBREAK_BIT = 21;

    localparam logic [3:0] ALU_R      = 4'b0000;
    localparam logic [3:0] ALU_I      = 4'b0001;
    localparam logic [3:0] ALU_BRANCH = 4'b0010;
    localparam logic [3:0] ALU_LOAD   = 4'b0011;
    localparam logic [3:0] ALU_STORE  = 4'b0100;
    localparam logic [3:0] ALU_JALR   = 4'b0101;
    localparam logic [3:0] ALU_JAL    = 4'b0110;
    localparam logic [3:0] ALU_AUIPC  = 4'b0111;
    localparam logic [3:0] ALU_LUI    = 4'b1000;
    localparam logic [3:0] ALU_MUL    = 4'b1001;

    localparam logic [1:0] RD_0 = 2'b00;
    localparam logic [1:0] RD_1 = 2'b01;
    localparam logic [1:0] RD_2 = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_COND = 2'b01;
    localparam logic [1:0] BR_JAL  = 2'b10;
    localparam logic [1:0] BR_JALR = 2'b11;

    // {mem_read, mem_write, reg_write, alu_src, mem_to_reg}
    localparam logic [4:0] FL_NONE  = 5'b00000;
    localparam logic [4:0] FL_LOAD  = 5'b10111;
    localparam logic [4:0] FL_STORE = 5'b01010;
    localparam logic [4:0] FL_IMM   = 5'b00110;
    localparam logic [4:0] FL_REG   = 5'b00100;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_RSTP = 2'd2;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] reg_data;
        logic [1:0] branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src;
        logic       mem_to_reg;
    } ctrl_t;

    function automatic ctrl_t mk_ctrl(logic [3:0] alu, logic [1:0] rd, logic [1:0] br, logic [4:0] fl);
        return {alu, rd, br, fl};
    endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if: fetch-side inputs and registered control outputs of the decode-stage control unit.
// slave = control unit side, master = driver/observer side.
interface pipe_control_unit_if;
    logic [31:0] inst;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic        resume;
    logic        out_valid;
    logic [3:0]  AluOp;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        ALUSrc;
    logic        MemToReg;
    logic [1:0]  RegData;
    logic [1:0]  Branch;
    logic        pc_rst;
    logic        pc_halt;
    logic        illegal;

    modport slave (
        input  inst, in_valid, stall, flush, resume,
        output out_valid, AluOp, MemRead, MemWrite, RegWrite, ALUSrc, MemToReg,
               RegData, Branch, pc_rst, pc_halt, illegal
    );

    modport master (
        output inst, in_valid, stall, flush, resume,
        input  out_valid, AluOp, MemRead, MemWrite, RegWrite, ALUSrc, MemToReg,
               RegData, Branch, pc_rst, pc_halt, illegal
    );
endinterface

// File: rtl/pipe_control_unit_ctrl_decode.sv
// ctrl_decode: combinational opcode decode into a control bundle plus ecall/fence/illegal flags.
// Ports: inst (32-bit instruction) in; ctrl bundle, is_ecall, is_fence, is_illegal out.
module ctrl_decode
    import pipe_control_unit_pkg::*;
#(
    parameter bit M_EXT = 1'b1
) (
    input  logic [31:0] inst,
    output ctrl_t       ctrl,
    output logic        is_ecall,
    output logic        is_fence,
    output logic        is_illegal
);
    logic [4:0] op;
    logic       unused_bits;

    assign op          = inst[6:2];
    assign unused_bits = ^{inst[31:26], inst[24:22], inst[20:7], inst[1:0]};

    // SYSTEM and FENCE fall through with an all-zero bundle
    always_comb begin
        ctrl       = '0;
        is_ecall   = 1'b0;
        is_fence   = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OPC_BRANCH:   ctrl = mk_ctrl(ALU_BRANCH, RD_1, BR_COND, FL_NONE);
            OPC_LOAD:     ctrl = mk_ctrl(ALU_LOAD, RD_2, BR_NONE, FL_LOAD);
            OPC_STORE:    ctrl = mk_ctrl(ALU_STORE, RD_1, BR_NONE, FL_STORE);
            OPC_JALR:     ctrl = mk_ctrl(ALU_JALR, RD_0, BR_JALR, FL_IMM);
            OPC_JAL:      ctrl = mk_ctrl(ALU_JAL, RD_0, BR_JAL, FL_IMM);
            OPC_OP_IMM:   ctrl = mk_ctrl(ALU_I, RD_2, BR_NONE, FL_IMM);
            OPC_AUIPC:    ctrl = mk_ctrl(ALU_AUIPC, RD_1, BR_NONE, FL_IMM);
            OPC_LUI:      ctrl = mk_ctrl(ALU_LUI, RD_2, BR_NONE, FL_IMM);
            OPC_OP: begin
                if (!inst[MUL_BIT])
                    ctrl = mk_ctrl(ALU_R, RD_2, BR_NONE, FL_REG);
                else if (M_EXT)
                    ctrl = mk_ctrl(ALU_MUL, RD_2, BR_NONE, FL_REG);
                else
                    is_illegal = 1'b1;
            end
            OPC_SYSTEM:   is_ecall = !inst[EBREAK_BIT];
            OPC_MISC_MEM: is_fence = 1'b1;
            default:      is_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: decode-stage control register with RUN/HALT/RSTP sequencing for ecall, fence and illegal ops.
// Ports: clk rising-edge clock; rst asynchronous active-low reset;
//        bus (slave): inst/in_valid/stall/flush/resume in, registered control bundle,
//        out_valid, pc_rst, pc_halt and one-cycle illegal out.
module pipe_control_unit
    import pipe_control_unit_pkg::*;
#(
    parameter bit          M_EXT            = 1'b1,
    parameter bit          HALT_RESUME      = 1'b1,
    parameter int unsigned FENCE_RST_CYCLES = 1,
    parameter bit          ILLEGAL_HALT     = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    pipe_control_unit_if.slave  bus
);
    localparam logic [3:0] CNT_INIT = 4'(FENCE_RST_CYCLES - 1);

    ctrl_t      dec, ctrl_q;
    logic       is_ecall, is_fence, is_illegal;
    logic [1:0] state, state_nx;
    logic [3:0] cnt;
    logic       accept, out_valid_q, pc_rst_q, pc_halt_q, illegal_q;

    ctrl_decode #(.M_EXT(M_EXT)) u_decode (
        .inst       (bus.inst),
        .ctrl       (dec),
        .is_ecall   (is_ecall),
        .is_fence   (is_fence),
        .is_illegal (is_illegal)
    );

    assign accept = bus.in_valid && !bus.stall && !bus.flush && state == ST_RUN;

    always_comb begin
        state_nx = ST_RUN;
        if (state == ST_RUN)
            state_nx = !accept ? ST_RUN :
                       (is_ecall || (is_illegal && ILLEGAL_HALT)) ? ST_HALT :
                       is_fence ? ST_RSTP : ST_RUN;
        else if (state == ST_HALT)
            state_nx = (bus.resume && HALT_RESUME) ? ST_RUN : ST_HALT;
        else if (state == ST_RSTP)
            state_nx = (cnt == '0) ? ST_RUN : ST_RSTP;
    end

    // pc_rst/pc_halt follow the next state so they rise in the cycle right after the trigger
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            pc_rst_q    <= 1'b0;
            pc_halt_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= (accept && is_fence) ? CNT_INIT :
                         (state == ST_RSTP && cnt != '0) ? cnt - 4'd1 : cnt;
            pc_rst_q  <= state_nx == ST_RSTP;
            pc_halt_q <= state_nx == ST_HALT;
            illegal_q <= accept && is_illegal;
            if (bus.flush || state != ST_RUN) begin
                ctrl_q      <= '0;
                out_valid_q <= 1'b0;
            end else if (!bus.stall) begin
                ctrl_q      <= accept ? dec : '0;
                out_valid_q <= accept && !is_illegal;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.AluOp     = ctrl_q.alu_op;
    assign bus.MemRead   = ctrl_q.mem_read;
    assign bus.MemWrite  = ctrl_q.mem_write;
    assign bus.RegWrite  = ctrl_q.reg_write;
    assign bus.ALUSrc    = ctrl_q.alu_src;
    assign bus.MemToReg  = ctrl_q.mem_to_reg;
    assign bus.RegData   = ctrl_q.reg_data;
    assign bus.Branch    = ctrl_q.branch;
    assign bus.pc_rst    = pc_rst_q;
    assign bus.pc_halt   = pc_halt_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: two control units (default and non-default parameters) against a cycle-level reference model.
module tb_pipe_control_unit;
    localparam int RUN = 0, HALT = 1, RSTP = 2;
    localparam int K_OK = 0, K_ECALL = 1, K_FENCE = 2, K_ILL = 3;

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_MUL   = 32'h023100B3;
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_FENCE = 32'h0000000F;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        in_valid, stall, flush, resume;
    logic [16:0] got0, got1;

    always #5 clk = ~clk;

    pipe_control_unit_if i0();
    pipe_control_unit_if i1();

    assign i0.inst = inst;
    assign i0.in_valid = in_valid;
    assign i0.stall = stall;
    assign i0.flush = flush;
    assign i0.resume = resume;
    assign i1.inst = inst;
    assign i1.in_valid = in_valid;
    assign i1.stall = stall;
    assign i1.flush = flush;
    assign i1.resume = resume;

    pipe_control_unit u0 (.clk(clk), .rst(rst), .bus(i0));

    pipe_control_unit #(
        .M_EXT(1'b0), .HALT_RESUME(1'b0), .FENCE_RST_CYCLES(3), .ILLEGAL_HALT(1'b1)
    ) u1 (.clk(clk), .rst(rst), .bus(i1));

    assign got0 = {i0.out_valid, i0.AluOp, i0.RegData, i0.Branch, i0.MemRead, i0.MemWrite,
                   i0.RegWrite, i0.ALUSrc, i0.MemToReg, i0.pc_rst, i0.pc_halt, i0.illegal};
    assign got1 = {i1.out_valid, i1.AluOp, i1.RegData, i1.Branch, i1.MemRead, i1.MemWrite,
                   i1.RegWrite, i1.ALUSrc, i1.MemToReg, i1.pc_rst, i1.pc_halt, i1.illegal};

    bit p_mext [2] = '{1'b1, 1'b0};
    bit p_hr   [2] = '{1'b1, 1'b0};
    bit p_ih   [2] = '{1'b0, 1'b1};
    int p_frc  [2] = '{1, 3};

    int          mode  [2];
    int          rem   [2];
    logic [13:0] m_out [2];
    logic        m_ill [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // bundle = {AluOp, RegData, Branch, MemRead, MemWrite, RegWrite, ALUSrc, MemToReg}
    function automatic void ref_dec(input logic [31:0] x, input bit mext, output logic [12:0] b, output int kind);
        b = '0;
        kind = K_OK;
        case (x[6:2])
            5'b11000: b = {4'd2, 2'd1, 2'd1, 5'b00000};
            5'b00000: b = {4'd3, 2'd2, 2'd0, 5'b10111};
            5'b01000: b = {4'd4, 2'd1, 2'd0, 5'b01010};
            5'b11001: b = {4'd5, 2'd0, 2'd3, 5'b00110};
            5'b11011: b = {4'd6, 2'd0, 2'd2, 5'b00110};
            5'b00100: b = {4'd1, 2'd2, 2'd0, 5'b00110};
            5'b00101: b = {4'd7, 2'd1, 2'd0, 5'b00110};
            5'b01101: b = {4'd8, 2'd2, 2'd0, 5'b00110};
            5'b01100: begin
                if (!x[25]) b = {4'd0, 2'd2, 2'd0, 5'b00100};
                else if (mext) b = {4'd9, 2'd2, 2'd0, 5'b00100};
                else kind = K_ILL;
            end
            5'b11100: kind = x[21] ? K_OK : K_ECALL;
            5'b00011: kind = K_FENCE;
            default:  kind = K_ILL;
        endcase
    endfunction

    function automatic logic [16:0] expected(input int k);
        return {m_out[k], mode[k] == RSTP, mode[k] == HALT, m_ill[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mode[k] = RUN;
            rem[k] = 0;
            m_out[k] = '0;
            m_ill[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [12:0] b;
            int kd;
            bit acc;
            ref_dec(inst, p_mext[k], b, kd);
            acc = in_valid && !stall && !flush && mode[k] == RUN;
            if (flush || mode[k] != RUN) m_out[k] = '0;
            else if (!stall) m_out[k] = (acc && kd != K_ILL) ? {1'b1, b} : '0;
            m_ill[k] = acc && kd == K_ILL;
            case (mode[k])
                RUN: if (acc) begin
                    if (kd == K_ECALL || (kd == K_ILL && p_ih[k])) mode[k] = HALT;
                    else if (kd == K_FENCE) begin
                        mode[k] = RSTP;
                        rem[k] = p_frc[k];
                    end
                end
                HALT: if (resume && p_hr[k]) mode[k] = RUN;
                default: begin
                    rem[k]--;
                    if (rem[k] == 0) mode[k] = RUN;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("dut0", {15'd0, got0}, {15'd0, expected(0)});
        check("dut1", {15'd0, got1}, {15'd0, expected(1)});
    endtask

    task automatic step(input logic [31:0] i, input logic v, input logic s, input logic f, input logic r);
        inst = i;
        in_valid = v;
        stall = s;
        flush = f;
        resume = r;
        @(posedge clk);
        #1;
        model_step();
        compare_all();
    endtask

    // asserted mid-cycle to exercise the asynchronous path
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 12))
            0:  x[6:2] = 5'b11000;
            1:  x[6:2] = 5'b00000;
            2:  x[6:2] = 5'b01000;
            3:  x[6:2] = 5'b11001;
            4:  x[6:2] = 5'b11011;
            5:  x[6:2] = 5'b00100;
            6:  x[6:2] = 5'b01100;
            7:  x[6:2] = 5'b00101;
            8:  x[6:2] = 5'b01101;
            9:  x[6:2] = 5'b11100;
            10: x[6:2] = 5'b00011;
            11: x[6:2] = 5'b01100;
            default: ;
        endcase
        x[1:0] = 2'b11;
        return x;
    endfunction

    initial begin
        rst = 1'b0;
        inst = '0;
        in_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        resume = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 1'b1;

        step(I_ADD, 1, 0, 0, 0);
        check("add_valid", {31'd0, i0.out_valid}, 32'd1);
        check("add_aluop", {28'd0, i0.AluOp}, 32'h0);
        check("add_regwrite", {31'd0, i0.RegWrite}, 32'd1);
        check("add_regdata", {30'd0, i0.RegData}, 32'h2);
        check("add_alusrc", {31'd0, i0.ALUSrc}, 32'd0);

        step(I_MUL, 1, 0, 0, 0);
        check("mul_aluop", {28'd0, i0.AluOp}, 32'h9);
        check("mul_illegal", {31'd0, i1.illegal}, 32'd1);
        check("mul_noext_valid", {31'd0, i1.out_valid}, 32'd0);
        step(I_ADD, 1, 0, 0, 0);
        check("illegal_pulse_end", {31'd0, i1.illegal}, 32'd0);
        do_reset();

        step(I_LW, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(rnd_inst(), 1, 1, 0, 0);
            check("lw_hold_memread", {31'd0, i0.MemRead}, 32'd1);
        end
        step(I_LW, 1, 1, 1, 0);
        check("stall_flush_bubble", {31'd0, i0.out_valid}, 32'd0);

        step(I_ECALL, 1, 0, 1, 0);
        check("flushed_ecall", {31'd0, i0.pc_halt}, 32'd0);
        step(I_FENCE, 1, 0, 1, 0);
        check("flushed_fence", {31'd0, i0.pc_rst}, 32'd0);

        step(I_ECALL, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(I_ADD, 1, 0, 0, 0);
            check("halt_held", {31'd0, i0.pc_halt}, 32'd1);
        end
        step(I_ADD, 1, 0, 0, 1);
        check("resume_exit", {31'd0, i0.pc_halt}, 32'd0);
        check("resume_inst_dropped", {31'd0, i0.out_valid}, 32'd0);
        check("no_resume_held", {31'd0, i1.pc_halt}, 32'd1);
        step(I_ADD, 1, 0, 0, 0);
        do_reset();

        step(I_FENCE, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(I_ADD, 1, 0, 0, 0);
        step(I_FENCE, 1, 0, 0, 0);
        step(I_ADD, 1, 0, 0, 0);
        check("rstp_second_cycle", {31'd0, i1.pc_rst}, 32'd1);
        do_reset();
        check("rstp_reset_clears", {31'd0, i1.pc_rst}, 32'd0);
        step(I_ADD, 1, 0, 0, 0);
        check("first_accept_after_rst", {31'd0, i1.out_valid}, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            step(rnd_inst(), $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) < 1, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
